// File: rtl/m_wbioarb_pkg.sv
// Shared definitions for the midgetv IO-bus arbiter.
//   - arb_state_e    : arbiter state encoding. The owner states are one-hot, so the
//                      state vector doubles as the grant vector.
//   - TODATA_DEFAULT : read data returned to a master whose access timed out.
//   - ADRW/DATW/SELW : Wishbone address, data and byte-select widths.
package m_wbioarb_pkg;

  localparam int unsigned ADRW = 32;
  localparam int unsigned DATW = 32;
  localparam int unsigned SELW = 4;

  localparam logic [DATW-1:0] TODATA_DEFAULT = 32'hffff_ffff;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/m_wbtimeout.sv
// Bus-timeout watchdog for a Wishbone slave port.
// Counts consecutive cycles of unacknowledged strobe. On the cycle the count sits at
// its terminal value (all ones) with no slave ACK, it raises timeout_o for one cycle
// so the master gets a substitute ACK, and sets a sticky error flag on the next edge.
//
// Ports:
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   stb_i     : strobe of the current bus owner (0 when the bus is idle)
//   ack_i     : slave acknowledge
//   clrerr_i  : clears buserr_o (a timeout in the same cycle takes precedence)
//   timeout_o : one-cycle substitute acknowledge
//   buserr_o  : sticky timeout flag
module m_wbtimeout #(
  parameter int unsigned TOWIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stb_i,
  input  logic ack_i,
  input  logic clrerr_i,
  output logic timeout_o,
  output logic buserr_o
);

  localparam logic [TOWIDTH-1:0] CntMax = '1;

  logic [TOWIDTH-1:0] cnt_q, cnt_d;
  logic               buserr_q, buserr_d;

  // A real ACK on the terminal cycle beats the timeout.
  assign timeout_o = stb_i && !ack_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d    = cnt_q;
    buserr_d = buserr_q;

    if (!stb_i || ack_i || timeout_o) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Setting wins over clearing so a coincident clear cannot hide a new error.
    if (timeout_o) begin
      buserr_d = 1'b1;
    end else if (clrerr_i) begin
      buserr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      buserr_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      buserr_q <= buserr_d;
    end
  end

  assign buserr_o = buserr_q;

endmodule

// File: rtl/m_wbioarb.sv
// Two-master Wishbone arbiter for the midgetv IO bus.
// Master 0 (core) and master 1 (debug/loader) share one IO slave port. Ownership is
// granted for a whole CYC burst with round-robin priority; there is always one idle
// cycle between owners. Responses are routed only to the owner, and a watchdog
// terminates accesses the slave never acknowledges.
//
// Ports:
//   CLK_I, RST_I_n       : clock, asynchronous active-low reset
//   m0_* / m1_*          : master CYC/STB/WE/ADR/DAT/SEL in, ACK/DAT out
//   s_*                  : slave CYC/STB/WE/ADR/DAT_W/SEL out, ACK/DAT_R in
//   gnt                  : one-hot current owner, 00 when idle
//   buserr, clrerr       : sticky timeout flag and its clear
module m_wbioarb
  import m_wbioarb_pkg::*;
#(
  parameter int unsigned     TOWIDTH = 4,
  parameter logic [DATW-1:0] TODATA  = TODATA_DEFAULT
) (
  input  logic            CLK_I,
  input  logic            RST_I_n,

  input  logic            m0_CYC_O,
  input  logic            m0_STB_O,
  input  logic            m0_WE_O,
  input  logic [ADRW-1:0] m0_ADR_O,
  input  logic [DATW-1:0] m0_DAT_O,
  input  logic [SELW-1:0] m0_SEL_O,
  output logic            m0_ACK_I,
  output logic [DATW-1:0] m0_DAT_I,

  input  logic            m1_CYC_O,
  input  logic            m1_STB_O,
  input  logic            m1_WE_O,
  input  logic [ADRW-1:0] m1_ADR_O,
  input  logic [DATW-1:0] m1_DAT_O,
  input  logic [SELW-1:0] m1_SEL_O,
  output logic            m1_ACK_I,
  output logic [DATW-1:0] m1_DAT_I,

  output logic            s_CYC,
  output logic            s_STB,
  output logic            s_WE,
  output logic [ADRW-1:0] s_ADR,
  output logic [DATW-1:0] s_DAT_W,
  output logic [SELW-1:0] s_SEL,
  input  logic            s_ACK,
  input  logic [DATW-1:0] s_DAT_R,

  output logic [1:0]      gnt,
  output logic            buserr,
  input  logic            clrerr
);

  arb_state_e state_q, state_d;
  // Master that owned the bus most recently; 1 out of reset so master 0 wins first tie.
  logic       last_q, last_d;

  logic            own_cyc, own_stb, own_we;
  logic [ADRW-1:0] own_adr;
  logic [DATW-1:0] own_dat;
  logic [SELW-1:0] own_sel;
  logic            resp_ack;
  logic [DATW-1:0] resp_dat;
  logic            to_ack;

  // Arbitration.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (m0_CYC_O && m1_CYC_O) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_CYC_O) begin
          state_d = StOwn0;
        end else if (m1_CYC_O) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!m0_CYC_O) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      StOwn1: begin
        if (!m1_CYC_O) begin
          state_d = StIdle;
          last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I_n) begin
    if (!RST_I_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Owner request mux; everything reads as zero while idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    unique case (state_q)
      StOwn0: begin
        own_cyc = m0_CYC_O;
        own_stb = m0_STB_O;
        own_we  = m0_WE_O;
        own_adr = m0_ADR_O;
        own_dat = m0_DAT_O;
        own_sel = m0_SEL_O;
      end
      StOwn1: begin
        own_cyc = m1_CYC_O;
        own_stb = m1_STB_O;
        own_we  = m1_WE_O;
        own_adr = m1_ADR_O;
        own_dat = m1_DAT_O;
        own_sel = m1_SEL_O;
      end
      default: ;
    endcase
  end

  m_wbtimeout #(
    .TOWIDTH (TOWIDTH)
  ) u_timeout (
    .clk_i     (CLK_I),
    .rst_ni    (RST_I_n),
    .stb_i     (own_stb),
    .ack_i     (s_ACK),
    .clrerr_i  (clrerr),
    .timeout_o (to_ack),
    .buserr_o  (buserr)
  );

  // The slave must not see a strobe on the cycle the watchdog answers for it.
  assign s_CYC   = own_cyc;
  assign s_STB   = own_stb & ~to_ack;
  assign s_WE    = own_we;
  assign s_ADR   = own_adr;
  assign s_DAT_W = own_dat;
  assign s_SEL   = own_sel;

  assign resp_ack = s_ACK | to_ack;
  assign resp_dat = to_ack ? TODATA : s_DAT_R;

  // Response demux: only the owner ever sees ACK or data.
  always_comb begin
    m0_ACK_I = 1'b0;
    m0_DAT_I = '0;
    m1_ACK_I = 1'b0;
    m1_DAT_I = '0;
    unique case (state_q)
      StOwn0: begin
        m0_ACK_I = resp_ack;
        m0_DAT_I = resp_dat;
      end
      StOwn1: begin
        m1_ACK_I = resp_ack;
        m1_DAT_I = resp_dat;
      end
      default: ;
    endcase
  end

  assign gnt = state_q;

endmodule

// File: tb/tb_m_wbioarb.sv
// Self-checking bench for m_wbioarb: table of single transfers plus hand-written
// sequences for arbitration, locking, timeout and asynchronous reset.
module tb_m_wbioarb;

  localparam logic [31:0] Key    = 32'ha5a5_0000;
  localparam logic [31:0] ToData = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rd, m1_rd;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_datw, s_datr;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;
  logic        buserr, clrerr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] mon_exp;

  int          slave_wait = 1;
  bit          slave_en = 1'b1;
  int          stb_cnt = 0;

  m_wbioarb dut (
    .CLK_I    (clk),
    .RST_I_n  (rst_n),
    .m0_CYC_O (m0_cyc),
    .m0_STB_O (m0_stb),
    .m0_WE_O  (m0_we),
    .m0_ADR_O (m0_adr),
    .m0_DAT_O (m0_dat),
    .m0_SEL_O (m0_sel),
    .m0_ACK_I (m0_ack),
    .m0_DAT_I (m0_rd),
    .m1_CYC_O (m1_cyc),
    .m1_STB_O (m1_stb),
    .m1_WE_O  (m1_we),
    .m1_ADR_O (m1_adr),
    .m1_DAT_O (m1_dat),
    .m1_SEL_O (m1_sel),
    .m1_ACK_I (m1_ack),
    .m1_DAT_I (m1_rd),
    .s_CYC    (s_cyc),
    .s_STB    (s_stb),
    .s_WE     (s_we),
    .s_ADR    (s_adr),
    .s_DAT_W  (s_datw),
    .s_SEL    (s_sel),
    .s_ACK    (s_ack),
    .s_DAT_R  (s_datr),
    .gnt      (gnt),
    .buserr   (buserr),
    .clrerr   (clrerr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave model: ACKs after slave_wait cycles of strobe (never if negative).
  always @(posedge clk) begin
    if (s_stb && !s_ack) stb_cnt = stb_cnt + 1;
    else stb_cnt = 0;
    #2;
    if (slave_en) begin
      s_datr = s_adr ^ Key;
      s_ack  = (slave_wait >= 0) && s_stb && (stb_cnt == slave_wait);
    end
  end

  // Scoreboard: every ACK must match a pending expectation of that master.
  always @(negedge clk) begin
    if (rst_n && m0_ack) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL m0_unexpected_ack: got ack 1, expected 0");
      end else begin
        mon_exp = q0.pop_front();
        check("m0_rdata", m0_rd, mon_exp);
      end
      check("m0_ack_gnt", 32'(gnt), 32'd1);
    end
    if (rst_n && m1_ack) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL m1_unexpected_ack: got ack 1, expected 0");
      end else begin
        mon_exp = q1.pop_front();
        check("m1_rdata", m1_rd, mon_exp);
      end
      check("m1_ack_gnt", 32'(gnt), 32'd2);
    end
  end

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel;
    end
  endtask

  // One access; slave-side signals are captured in the ACK cycle.
  task automatic m_xfer(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input logic [31:0] exp_rd, input bit keep_cyc,
                        output logic [1:0] o_gnt, output logic [31:0] o_adr,
                        output logic [31:0] o_datw, output logic o_we,
                        output logic [3:0] o_sel);
    bit got;
    got = 1'b0;
    o_gnt = '0; o_adr = '0; o_datw = '0; o_we = 1'b0; o_sel = '0;
    if (m == 0) q0.push_back(exp_rd);
    else q1.push_back(exp_rd);
    @(posedge clk); #1;
    drive_m(m, 1'b1, 1'b1, we, adr, dat, sel);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        o_gnt = gnt; o_adr = s_adr; o_datw = s_datw; o_we = s_we; o_sel = s_sel;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL m%0d_ack_wait: got no ack in 40 cycles, expected ack", m);
    end
    @(posedge clk); #1;
    drive_m(m, keep_cyc, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic m_simple(input int m, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input bit keep_cyc);
    logic [1:0]  g;
    logic [31:0] a, d;
    logic        w;
    logic [3:0]  s;
    m_xfer(m, we, adr, dat, 4'hf, adr ^ Key, keep_cyc, g, a, d, w, s);
  endtask

  typedef struct {
    int          m;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wt;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[6];
  logic [1:0]  rr_exp[9];
  logic [1:0]  trace[9];
  logic [1:0]  o_gnt;
  logic [31:0] o_adr, o_datw;
  logic        o_we;
  logic [3:0]  o_sel;
  int          bad_gnt, bad_ack, to_idx, early;
  logic        to_stb, to_err;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1'b1, 32'h6000_0004, 32'h0000_0007, 4'hf, 1, 2'b01, 32'h0};
    vecs[1] = '{1, 1'b0, 32'h6000_0010, 32'h0000_0000, 4'hf, 0, 2'b10, 32'h0};
    vecs[2] = '{1, 1'b1, 32'h6000_0008, 32'hdead_beef, 4'h3, 2, 2'b10, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h6000_0000, 32'h0000_0000, 4'h1, 3, 2'b01, 32'h0};
    vecs[4] = '{0, 1'b1, 32'h6000_000c, 32'h0000_1234, 4'hc, 0, 2'b01, 32'h0};
    vecs[5] = '{1, 1'b0, 32'h6000_0014, 32'h0000_0000, 4'hf, 1, 2'b10, 32'h0};
    foreach (vecs[i]) vecs[i].exp_rd = vecs[i].adr ^ Key;
    rr_exp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};

    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ack = 1'b0; s_datr = 32'h0; clrerr = 1'b0;

    // Reset state, with a request pending that must not be granted.
    repeat (2) @(posedge clk);
    #1; m1_cyc = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_s_stb", 32'(s_stb), 32'd0);
    check("rst_s_adr", s_adr, 32'd0);
    check("rst_m0_ack", 32'(m0_ack), 32'd0);
    check("rst_m1_ack", 32'(m1_ack), 32'd0);
    check("rst_m1_dat", m1_rd, 32'd0);
    check("rst_buserr", 32'(buserr), 32'd0);
    m1_cyc = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;

    // m0 single write, slave ACKs one cycle after strobe.
    slave_wait = 1;
    q0.push_back(32'h6000_0004 ^ Key);
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h6000_0004, 32'd7, 4'hf);
    @(negedge clk);
    check("t1_gnt_req_cycle", 32'(gnt), 32'd0);
    @(negedge clk);
    check("t1_gnt_granted", 32'(gnt), 32'd1);
    check("t1_s_adr", s_adr, 32'h6000_0004);
    check("t1_s_datw", s_datw, 32'd7);
    check("t1_s_stb", 32'(s_stb), 32'd1);
    check("t1_ack_early", 32'(m0_ack), 32'd0);
    @(negedge clk);
    check("t1_m0_ack", 32'(m0_ack), 32'd1);
    check("t1_s_ack", 32'(s_ack), 32'd1);
    check("t1_m1_ack", 32'(m1_ack), 32'd0);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Table of single transfers.
    foreach (vecs[i]) begin
      slave_wait = vecs[i].wt;
      m_xfer(vecs[i].m, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_rd,
             1'b0, o_gnt, o_adr, o_datw, o_we, o_sel);
      check($sformatf("vec%0d_gnt", i), 32'(o_gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_s_adr", i), o_adr, vecs[i].adr);
      check($sformatf("vec%0d_s_datw", i), o_datw, vecs[i].dat);
      check($sformatf("vec%0d_s_we", i), 32'(o_we), 32'(vecs[i].we));
      check($sformatf("vec%0d_s_sel", i), 32'(o_sel), 32'(vecs[i].sel));
    end

    // Simultaneous requests, twice: m0 first both times, one idle cycle between owners.
    slave_wait = 1;
    for (int r = 0; r < 2; r++) begin
      fork
        m_simple(0, 1'b1, 32'h6000_0020, 32'h11, 1'b0);
        m_simple(1, 1'b1, 32'h6000_0024, 32'h22, 1'b0);
        begin
          @(posedge clk);
          for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            trace[i] = gnt;
          end
        end
      join
      for (int i = 0; i < 9; i++)
        check($sformatf("rr%0d_gnt_c%0d", r, i), 32'(trace[i]), 32'(rr_exp[i]));
    end

    // m1 holds CYC over three strobes while m0 waits.
    bad_gnt = 0;
    bad_ack = 0;
    fork
      begin
        m_simple(1, 1'b0, 32'h6000_0040, 32'h0, 1'b1);
        m_simple(1, 1'b1, 32'h6000_0044, 32'h33, 1'b1);
        m_simple(1, 1'b0, 32'h6000_0048, 32'h0, 1'b0);
      end
      begin
        @(posedge clk);
        m_simple(0, 1'b1, 32'h6000_004c, 32'h44, 1'b0);
      end
      begin
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        for (int n = 0; n < 60; n++) begin
          @(negedge clk);
          if (!m1_cyc) break;
          if (gnt !== 2'b10) bad_gnt++;
          if (m0_ack) bad_ack++;
        end
      end
    join
    check("lock_gnt_held", 32'(bad_gnt), 32'd0);
    check("lock_m0_no_ack", 32'(bad_ack), 32'd0);

    // Timeout: slave never answers.
    slave_wait = -1;
    q0.push_back(ToData);
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h6000_0008, 32'h0, 4'hf);
    to_idx = -1;
    to_stb = 1'b1;
    to_err = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m0_ack) begin
        to_idx = i;
        to_stb = s_stb;
        to_err = buserr;
        break;
      end
    end
    check("to_ack_cycle", 32'(to_idx), 32'd16);
    check("to_s_stb_forced", 32'(to_stb), 32'd0);
    check("to_buserr_same_cycle", 32'(to_err), 32'd0);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("to_buserr_set", 32'(buserr), 32'd1);
    @(posedge clk); #1; clrerr = 1'b1;
    @(posedge clk); #1; clrerr = 1'b0;
    @(negedge clk);
    check("to_buserr_cleared", 32'(buserr), 32'd0);

    // Timeout coinciding with clrerr leaves buserr set.
    q0.push_back(ToData);
    @(posedge clk); #1;
    clrerr = 1'b1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h6000_0018, 32'h0, 4'hf);
    to_idx = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m0_ack) begin
        to_idx = i;
        break;
      end
    end
    check("to2_ack_cycle", 32'(to_idx), 32'd16);
    @(posedge clk); #1;
    clrerr = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("to2_buserr_kept", 32'(buserr), 32'd1);
    @(posedge clk); #1; clrerr = 1'b1;
    @(posedge clk); #1; clrerr = 1'b0;

    // Slave ACK on the cycle the timeout would fire: ACK wins, no error.
    slave_en = 1'b0;
    s_ack = 1'b0;
    s_datr = 32'h1234_5678;
    q0.push_back(32'h1234_5678);
    early = 0;
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b0, 32'h6000_001c, 32'h0, 4'hf);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (m0_ack) early++;
    end
    @(posedge clk); #2;
    s_ack = 1'b1;
    @(negedge clk);
    check("tie_m0_ack", 32'(m0_ack), 32'd1);
    check("tie_s_stb", 32'(s_stb), 32'd1);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    s_ack = 1'b0;
    @(negedge clk);
    check("tie_buserr", 32'(buserr), 32'd0);
    check("tie_no_early_ack", 32'(early), 32'd0);
    slave_en = 1'b1;

    // Asynchronous reset mid-access; m0 owned last, so only the reset makes m0 win next.
    slave_wait = -1;
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b1, 1'b1, 32'h6000_0030, 32'h55, 4'hf);
    @(posedge clk); #1;
    drive_m(1, 1'b1, 1'b1, 1'b0, 32'h6000_0034, 32'h0, 4'hf);
    @(negedge clk);
    check("ar_pre_gnt", 32'(gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt", 32'(gnt), 32'd0);
    check("ar_s_cyc", 32'(s_cyc), 32'd0);
    check("ar_s_stb", 32'(s_stb), 32'd0);
    check("ar_s_we", 32'(s_we), 32'd0);
    check("ar_s_adr", s_adr, 32'd0);
    check("ar_s_datw", s_datw, 32'd0);
    check("ar_s_sel", 32'(s_sel), 32'd0);
    check("ar_m0_ack", 32'(m0_ack), 32'd0);
    check("ar_m0_dat", m0_rd, 32'd0);
    check("ar_m1_ack", 32'(m1_ack), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ar_first_gnt", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("end_gnt_idle", 32'(gnt), 32'd0);
    check("sb_queues_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
